s100_bus_cycle_seq: RTL and testbench
=====================================

// Module: s100_bus_cycle_seq
// PURPOSE
//  Sequences single S-100 bus cycles (mem rd/wr, I/O rd/wr) for the FPGA SBC master.
//  Takes one request at a time from on-chip logic and drives address, data-out and
//  status/strobe pins through T1/T2/T3 phases. Returns read data or a timeout error.
//  Replaces the free-running counter drive of the address/DO/strobe pins.
// PARAMETERS
//  WAIT_STATES  0    forced T2 wait cycles before XRDY is honoured (0..15)
//  TIMEOUT      255  max T2 cycles waiting on XRDY before abort (1..255)
// PORTS
//  pll0_2MHz     in   1   clock; all logic on posedge
//  s100_n_RESET  in   1   async active-low reset
//  F_in_sdsb     in   1   1 = bus held by another master; no new cycle may start
//  req_valid     in   1   request present
//  req_ready     out  1   request accepted when req_valid & req_ready
//  req_type      in   2   00 MEMRD, 01 MEMWR, 10 IORD, 11 IOWR
//  req_addr      in   20  A19..A0 (I/O cycles use [7:0], upper bits driven as given)
//  req_wdata     in   8   write data
//  rsp_valid     out  1   one-cycle completion pulse
//  rsp_rdata     out  8   read data (8'hFF on timeout or write)
//  rsp_err       out  1   1 = timeout abort, valid with rsp_valid
//  s100_DI       in   8   S-100 data-in bus
//  s100_XRDY     in   1   slave ready; 0 extends T2
//  S100adr0_15   out  16  A15..A0
//  S100adr16_19  out  4   board-reversed: [0]=A16 ... [3]=A19 wired as A19..A16
//  s100_DO       out  8   S-100 data-out bus
//  s100_pSYNC    out  1   active-high, T1 only
//  s100_pSTVAL   out  1   active-low, T1 only
//  s100_pDBIN    out  1   active-high read strobe
//  s100_n_pWR    out  1   active-low write strobe
//  s100_sMWRT, s100_sOUT, s100_sINP  out 1 each  status, active-high
// BEHAVIOUR
//  Reset (async, any state): state IDLE; addr=0, DO=0, pSYNC=0, pSTVAL=1, pDBIN=0,
//   n_pWR=1, sMWRT/sOUT/sINP=0, rsp_valid=0, rsp_rdata=8'hFF, rsp_err=0, req_ready=0.
//  IDLE: req_ready = !F_in_sdsb. Accept latches type/addr/wdata; next state T1.
//  T1 (1 cycle): addr driven from latch; status set (sMWRT=MEMWR, sOUT=IOWR, sINP=IORD);
//   pSYNC=1, pSTVAL=0; DO=wdata for writes. -> T2.
//  T2: pDBIN=1 (reads) or n_pWR=0 (writes); wait counter loaded WAIT_STATES at entry.
//   Exit to T3 when counter==0 and XRDY==1; reads capture s100_DI into rsp_rdata on that
//   edge. Timeout counter counts T2 cycles; at TIMEOUT -> T3 with err, rdata=8'hFF.
//  T3 (1 cycle): strobes inactive, addr/status/DO held; rsp_valid=1. -> IDLE.
//  IDLE after T3: status cleared; addr and DO hold last value.
//  Latency: accept edge -> rsp_valid 3 cycles later min (WAIT_STATES=0, XRDY=1);
//   max throughput one cycle per 4 clocks (req_ready=0 outside IDLE).
//  F_in_sdsb rising mid-cycle: current cycle completes normally; only gates IDLE accept.
//  XRDY sampled only in T2; ignored elsewhere. Write rsp_rdata = 8'hFF.
//  Strobes pDBIN/n_pWR never both active; never active outside T2.
// STRUCTURE
//  s100_pkg: req_type encodings, state enum (IDLE,T1,T2,T3), reset-value constants.
//  Sub-module s100_wait_timer: wait-state down-counter + timeout counter, outputs
//   wait_done and timed_out; loaded on T2 entry.
// TESTING
//  MEMRD addr 20'h1_2345, DI=8'h5A, XRDY=1 -> pins A15..0=16'h2345, reversed A16..19,
//   pSYNC/pSTVAL one cycle, pDBIN one cycle, rsp_rdata=8'h5A, rsp_valid 3 cycles after accept.
//  IOWR addr 8'h7F, wdata 8'hC3 -> sOUT=1 T1..T3, DO=8'hC3, n_pWR=0 one cycle, rsp_err=0.
//  MEMWR, XRDY held 0 for 5 T2 cycles, WAIT_STATES=2 -> n_pWR low 6 cycles, sMWRT=1, done.
//  IORD, XRDY stuck 0, TIMEOUT=8 -> T3 after 8 T2 cycles, rsp_err=1, rsp_rdata=8'hFF.
//  F_in_sdsb=1 with req_valid=1 -> req_ready=0, no pSYNC; F_in_sdsb rising in T2 -> cycle completes.
//  s100_n_RESET low in T2 -> same-cycle return to reset values; next request runs cleanly.

Source files
------------

// File: rtl/s100_pkg.sv
// Shared encodings and reset values for the S-100 bus-cycle sequencer.
package s100_pkg;

   typedef enum logic [1:0] {
      REQ_MEMRD = 2'b00,
      REQ_MEMWR = 2'b01,
      REQ_IORD  = 2'b10,
      REQ_IOWR  = 2'b11
   } req_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_T1   = 2'd1,
      ST_T2   = 2'd2,
      ST_T3   = 2'd3
   } bus_state_e;

   localparam logic [7:0]  RDATA_RST = 8'hFF;
   localparam logic [15:0] ADR_LO_RST = 16'h0000;
   localparam logic [3:0]  ADR_HI_RST = 4'h0;
   localparam logic [7:0]  DO_RST     = 8'h00;

   // Both write encodings have bit 0 set.
   function automatic logic is_write(input req_type_e t);
      return t[0];
   endfunction

endpackage

// File: rtl/s100_wait_timer.sv
// T2 wait-state and timeout down-counters, both loaded on the cycle before T2.
module s100_wait_timer #(
   parameter int WAIT_STATES = 0,
   parameter int TIMEOUT     = 255
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic load,
   input  logic run,
   output logic wait_done,
   output logic timed_out
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
   // Terminal count reached in the TIMEOUT-th T2 cycle, so load one less.
   localparam logic [7:0] TMO_INIT  = 8'(TIMEOUT - 1);

   logic [3:0] wait_cnt;
   logic [7:0] tmo_cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wait_cnt <= '0;
         tmo_cnt  <= '0;
      end else if (load) begin
         wait_cnt <= WAIT_INIT;
         tmo_cnt  <= TMO_INIT;
      end else if (run) begin
         if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
         if (tmo_cnt != 8'd0)  tmo_cnt  <= tmo_cnt - 8'd1;
      end
   end

   assign wait_done = (wait_cnt == 4'd0);
   assign timed_out = (tmo_cnt == 8'd0);

endmodule

// File: rtl/s100_bus_cycle_seq.sv
// Runs one S-100 bus cycle (mem/IO read/write) per request through T1/T2/T3.
//
// state | meaning
// IDLE  | waiting for a request; status cleared, address/DO hold last value
// T1    | address and status valid, pSYNC high, pSTVAL low
// T2    | read or write strobe active, waiting on wait states and XRDY
// T3    | strobes released, response pulse out
module s100_bus_cycle_seq
   import s100_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int TIMEOUT     = 255
) (
   input  logic        pll0_2MHz,
   input  logic        s100_n_RESET,
   input  logic        F_in_sdsb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_type,
   input  logic [19:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   input  logic [7:0]  s100_DI,
   input  logic        s100_XRDY,
   output logic [15:0] S100adr0_15,
   output logic [3:0]  S100adr16_19,
   output logic [7:0]  s100_DO,
   output logic        s100_pSYNC,
   output logic        s100_pSTVAL,
   output logic        s100_pDBIN,
   output logic        s100_n_pWR,
   output logic        s100_sMWRT,
   output logic        s100_sOUT,
   output logic        s100_sINP
);

   bus_state_e state;
   req_type_e  type_q;
   req_type_e  type_in;
   logic       idle_q;
   logic       accept;
   logic       wait_done;
   logic       timed_out;
   logic       complete;

   assign type_in   = req_type_e'(req_type);
   // idle_q is registered so req_ready stays low through reset and the first clock.
   assign req_ready = idle_q & ~F_in_sdsb;
   assign accept    = req_valid & req_ready;
   assign complete  = wait_done & s100_XRDY;

   s100_wait_timer #(
      .WAIT_STATES (WAIT_STATES),
      .TIMEOUT     (TIMEOUT)
   ) u_wait_timer (
      .clk_sys   (pll0_2MHz),
      .rst_b     (s100_n_RESET),
      .load      (state == ST_T1),
      .run       (state == ST_T2),
      .wait_done (wait_done),
      .timed_out (timed_out)
   );

   always_ff @(posedge pll0_2MHz or negedge s100_n_RESET) begin
      if (!s100_n_RESET) begin
         state        <= ST_IDLE;
         type_q       <= REQ_MEMRD;
         idle_q       <= 1'b0;
         S100adr0_15  <= ADR_LO_RST;
         S100adr16_19 <= ADR_HI_RST;
         s100_DO      <= DO_RST;
         s100_pSYNC   <= 1'b0;
         s100_pSTVAL  <= 1'b1;
         s100_pDBIN   <= 1'b0;
         s100_n_pWR   <= 1'b1;
         s100_sMWRT   <= 1'b0;
         s100_sOUT    <= 1'b0;
         s100_sINP    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= RDATA_RST;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               if (accept) begin
                  state        <= ST_T1;
                  idle_q       <= 1'b0;
                  type_q       <= type_in;
                  S100adr0_15  <= req_addr[15:0];
                  // Bit i carries A(16+i); the board routes these pins in reverse.
                  S100adr16_19 <= req_addr[19:16];
                  if (is_write(type_in)) s100_DO <= req_wdata;
                  s100_sMWRT   <= (type_in == REQ_MEMWR);
                  s100_sOUT    <= (type_in == REQ_IOWR);
                  s100_sINP    <= (type_in == REQ_IORD);
                  s100_pSYNC   <= 1'b1;
                  s100_pSTVAL  <= 1'b0;
               end else begin
                  idle_q <= 1'b1;
               end
            end
            ST_T1: begin
               state       <= ST_T2;
               s100_pSYNC  <= 1'b0;
               s100_pSTVAL <= 1'b1;
               s100_pDBIN  <= ~is_write(type_q);
               s100_n_pWR  <= ~is_write(type_q);
            end
            ST_T2: begin
               // A ready slave wins over a timeout that lands on the same cycle.
               if (complete || timed_out) begin
                  state      <= ST_T3;
                  s100_pDBIN <= 1'b0;
                  s100_n_pWR <= 1'b1;
                  rsp_valid  <= 1'b1;
                  rsp_err    <= ~complete;
                  rsp_rdata  <= (complete && !is_write(type_q)) ? s100_DI : RDATA_RST;
               end
            end
            ST_T3: begin
               state      <= ST_IDLE;
               idle_q     <= 1'b1;
               rsp_valid  <= 1'b0;
               rsp_err    <= 1'b0;
               s100_sMWRT <= 1'b0;
               s100_sOUT  <= 1'b0;
               s100_sINP  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_s100_bus_cycle_seq.sv
// Directed bench for the S-100 bus-cycle sequencer; instance A has no wait states
// and an 8-cycle timeout, instance B has two wait states and the default timeout.
module tb_s100_bus_cycle_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sdsb = 1'b0;
   logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
   logic [1:0]  req_type = 2'b00;
   logic [19:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic [7:0]  di = '0;
   logic        xrdy = 1'b1;

   logic        req_ready_a, rsp_valid_a, rsp_err_a, psync_a, pstval_a, pdbin_a, npwr_a;
   logic        smwrt_a, sout_a, sinp_a;
   logic [7:0]  rsp_rdata_a, do_a;
   logic [15:0] alo_a;
   logic [3:0]  ahi_a;
   logic        req_ready_b, rsp_valid_b, rsp_err_b, psync_b, pstval_b, pdbin_b, npwr_b;
   logic        smwrt_b, sout_b, sinp_b;
   logic [7:0]  rsp_rdata_b, do_b;
   logic [15:0] alo_b;
   logic [3:0]  ahi_b;

   always #5 clk = ~clk;

   s100_bus_cycle_seq #(.WAIT_STATES(0), .TIMEOUT(8)) u_dut_a (
      .pll0_2MHz(clk), .s100_n_RESET(rst_n), .F_in_sdsb(sdsb),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_type(req_type),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
      .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .s100_DI(di), .s100_XRDY(xrdy),
      .S100adr0_15(alo_a), .S100adr16_19(ahi_a), .s100_DO(do_a),
      .s100_pSYNC(psync_a), .s100_pSTVAL(pstval_a), .s100_pDBIN(pdbin_a),
      .s100_n_pWR(npwr_a), .s100_sMWRT(smwrt_a), .s100_sOUT(sout_a), .s100_sINP(sinp_a));

   s100_bus_cycle_seq #(.WAIT_STATES(2), .TIMEOUT(255)) u_dut_b (
      .pll0_2MHz(clk), .s100_n_RESET(rst_n), .F_in_sdsb(sdsb),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_type(req_type),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
      .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .s100_DI(di), .s100_XRDY(xrdy),
      .S100adr0_15(alo_b), .S100adr16_19(ahi_b), .s100_DO(do_b),
      .s100_pSYNC(psync_b), .s100_pSTVAL(pstval_b), .s100_pDBIN(pdbin_b),
      .s100_n_pWR(npwr_b), .s100_sMWRT(smwrt_b), .s100_sOUT(sout_b), .s100_sINP(sinp_b));

   bit          inst_sel = 1'b0;
   logic        m_ready, m_valid, m_err, m_sync, m_stval, m_dbin, m_nwr;
   logic [2:0]  m_stat;
   logic [7:0]  m_rdata, m_do;
   logic [15:0] m_alo;
   logic [3:0]  m_ahi;

   assign m_ready = inst_sel ? req_ready_b : req_ready_a;
   assign m_valid = inst_sel ? rsp_valid_b : rsp_valid_a;
   assign m_err   = inst_sel ? rsp_err_b   : rsp_err_a;
   assign m_sync  = inst_sel ? psync_b     : psync_a;
   assign m_stval = inst_sel ? pstval_b    : pstval_a;
   assign m_dbin  = inst_sel ? pdbin_b     : pdbin_a;
   assign m_nwr   = inst_sel ? npwr_b      : npwr_a;
   assign m_stat  = inst_sel ? {smwrt_b, sout_b, sinp_b} : {smwrt_a, sout_a, sinp_a};
   assign m_rdata = inst_sel ? rsp_rdata_b : rsp_rdata_a;
   assign m_do    = inst_sel ? do_b        : do_a;
   assign m_alo   = inst_sel ? alo_b       : alo_a;
   assign m_ahi   = inst_sel ? ahi_b       : ahi_a;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Results of the most recent transaction.
   int         r_lat, r_rd, r_wr, r_sync, r_stval, r_stat;
   bit         r_overlap;
   logic [7:0] r_rdata, r_do;
   logic       r_err;
   logic [2:0] r_stat_t1;
   logic [15:0] r_alo;
   logic [3:0] r_ahi;

   // Runs one request; XRDY is held low for the first 'low' T2 cycles.
   task automatic run_txn(input bit inst, input logic [1:0] t, input logic [19:0] a,
                          input logic [7:0] wd, input int low, input bit sdsb_t2);
      int n;
      int cyc;
      @(negedge clk);
      inst_sel  = inst;
      req_type  = t;
      req_addr  = a;
      req_wdata = wd;
      xrdy      = (low == 0);
      if (inst) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      r_lat = 0; r_rd = 0; r_wr = 0; r_sync = 0; r_stval = 0; r_stat = 0;
      r_overlap = 1'b0; r_rdata = 8'h00; r_err = 1'b0;
      r_stat_t1 = 3'b000; r_alo = '0; r_ahi = '0; r_do = '0;
      n = 0;
      while (!m_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!m_ready) begin
         check_val("req_ready_timeout", 32'(m_ready), 1);
         req_valid_a = 1'b0;
         req_valid_b = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      cyc = 1;
      while (cyc < 40) begin
         if (m_sync) r_sync++;
         if (!m_stval) r_stval++;
         if (m_dbin) r_rd++;
         if (!m_nwr) r_wr++;
         if (m_dbin && !m_nwr) r_overlap = 1'b1;
         if (m_dbin || !m_nwr) begin
            if (sdsb_t2) sdsb = 1'b1;
            xrdy = ((r_rd + r_wr) > low);
         end
         if (m_stat != 3'b000) r_stat++;
         if (cyc == 1) begin
            r_stat_t1 = m_stat;
            r_alo = m_alo;
            r_ahi = m_ahi;
            r_do  = m_do;
         end
         if (m_valid) begin
            r_lat   = cyc;
            r_rdata = m_rdata;
            r_err   = m_err;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      if (r_lat == 0) check_val("rsp_valid_timeout", 32'(m_valid), 1);
      xrdy = 1'b1;
   endtask

   initial begin
      int bad;

      // Reset values
      #1 rst_n = 1'b0;
      sdsb = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_req_ready", 32'(req_ready_a), 0);
      check_val("rst_pstval", 32'(pstval_a), 1);
      check_val("rst_npwr", 32'(npwr_b), 1);
      check_val("rst_rdata", 32'(rsp_rdata_a), 'hFF);
      check_val("rst_status", 32'({smwrt_a, sout_a, sinp_a, psync_a, pdbin_a, rsp_valid_a}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("sdsb_gates_ready", 32'(req_ready_a), 0);
      sdsb = 1'b0;
      #1 check_val("ready_after_reset", 32'(req_ready_a), 1);

      // Memory read, no wait states
      di = 8'h5A;
      run_txn(1'b0, 2'b00, 20'h1_2345, 8'h00, 0, 1'b0);
      check_val("memrd_lat", r_lat, 3);
      check_val("memrd_alo", 32'(r_alo), 'h2345);
      check_val("memrd_ahi", 32'(r_ahi), 'h1);
      check_val("memrd_sync_cnt", r_sync, 1);
      check_val("memrd_stval_cnt", r_stval, 1);
      check_val("memrd_dbin_cnt", r_rd, 1);
      check_val("memrd_wr_cnt", r_wr, 0);
      check_val("memrd_stat", 32'(r_stat_t1), 0);
      check_val("memrd_rdata", 32'(r_rdata), 'h5A);
      check_val("memrd_err", 32'(r_err), 0);

      // I/O write
      run_txn(1'b0, 2'b11, 20'h0_007F, 8'hC3, 0, 1'b0);
      check_val("iowr_lat", r_lat, 3);
      check_val("iowr_stat_t1", 32'(r_stat_t1), 'b010);
      check_val("iowr_stat_cnt", r_stat, 3);
      check_val("iowr_do", 32'(r_do), 'hC3);
      check_val("iowr_wr_cnt", r_wr, 1);
      check_val("iowr_rd_cnt", r_rd, 0);
      check_val("iowr_err", 32'(r_err), 0);
      check_val("iowr_rdata", 32'(r_rdata), 'hFF);
      @(negedge clk);
      check_val("idle_status_clr", 32'({smwrt_a, sout_a, sinp_a}), 0);
      check_val("idle_do_hold", 32'(do_a), 'hC3);
      check_val("idle_addr_hold", 32'(alo_a), 'h007F);
      check_val("idle_rsp_valid", 32'(rsp_valid_a), 0);

      // Memory write, two wait states, XRDY low for five T2 cycles
      run_txn(1'b1, 2'b01, 20'h0_A5A5, 8'h3C, 5, 1'b0);
      check_val("memwr_ws_wr_cnt", r_wr, 6);
      check_val("memwr_ws_stat_t1", 32'(r_stat_t1), 'b100);
      check_val("memwr_ws_stat_cnt", r_stat, 8);
      check_val("memwr_ws_lat", r_lat, 8);
      check_val("memwr_ws_err", 32'(r_err), 0);
      check_val("memwr_ws_overlap", 32'(r_overlap), 0);

      // Memory write, wait states only
      run_txn(1'b1, 2'b01, 20'h0_0100, 8'h81, 0, 1'b0);
      check_val("memwr_w2_wr_cnt", r_wr, 3);
      check_val("memwr_w2_lat", r_lat, 5);
      check_val("memwr_w2_do", 32'(r_do), 'h81);

      // I/O read timeout
      di = 8'h77;
      run_txn(1'b0, 2'b10, 20'h0_0042, 8'h00, 255, 1'b0);
      check_val("iord_tmo_rd_cnt", r_rd, 8);
      check_val("iord_tmo_lat", r_lat, 10);
      check_val("iord_tmo_err", 32'(r_err), 1);
      check_val("iord_tmo_rdata", 32'(r_rdata), 'hFF);
      check_val("iord_tmo_stat_t1", 32'(r_stat_t1), 'b001);
      check_val("iord_tmo_stat_cnt", r_stat, 10);

      // Bus held by another master
      @(negedge clk);
      inst_sel = 1'b0;
      sdsb = 1'b1;
      req_type = 2'b00;
      req_valid_a = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (req_ready_a || psync_a) bad++;
      end
      check_val("sdsb_no_start", bad, 0);
      req_valid_a = 1'b0;
      sdsb = 1'b0;

      // Bus grab in mid-cycle lets the current cycle finish
      di = 8'h3E;
      run_txn(1'b0, 2'b00, 20'h0_1234, 8'h00, 0, 1'b1);
      check_val("sdsb_t2_lat", r_lat, 3);
      check_val("sdsb_t2_rdata", 32'(r_rdata), 'h3E);
      @(negedge clk);
      check_val("sdsb_t2_ready_low", 32'(req_ready_a), 0);
      sdsb = 1'b0;
      #1 check_val("sdsb_release_ready", 32'(req_ready_a), 1);

      // Reset asserted during T2
      @(negedge clk);
      inst_sel = 1'b0;
      req_type = 2'b10;
      req_addr = 20'h0_00AA;
      xrdy = 1'b0;
      req_valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_a = 1'b0;
      @(negedge clk);
      check_val("rst_t2_pre_dbin", 32'(pdbin_a), 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_t2_dbin", 32'(pdbin_a), 0);
      check_val("rst_t2_addr", 32'(alo_a), 0);
      check_val("rst_t2_pstval", 32'(pstval_a), 1);
      check_val("rst_t2_sinp", 32'(sinp_a), 0);
      check_val("rst_t2_rdata", 32'(rsp_rdata_a), 'hFF);
      check_val("rst_t2_ready", 32'(req_ready_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      xrdy = 1'b1;

      // Clean cycle after reset
      di = 8'hA6;
      run_txn(1'b0, 2'b00, 20'hF_0001, 8'h00, 0, 1'b0);
      check_val("post_rst_lat", r_lat, 3);
      check_val("post_rst_rdata", 32'(r_rdata), 'hA6);
      check_val("post_rst_ahi", 32'(r_ahi), 'hF);
      check_val("post_rst_alo", 32'(r_alo), 'h0001);
      check_val("post_rst_err", 32'(r_err), 0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
